// File: rtl/led7seg_pkg.sv
// Shared constants and hex-to-segment lookup for the 4-digit 7-segment display path.
package led7seg_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-high cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] HEX2SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        return HEX2SEG[code];
    endfunction

endpackage

// File: rtl/led7seg_hex_decode.sv
// Combinational hex-to-7-segment decode with selectable cathode polarity.
module led7seg_hex_decode
    import led7seg_pkg::*;
#(
    parameter int SEG_ACT_LOW = 1
) (
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    logic [6:0] w_seg_hi;

    always_comb begin
        w_seg_hi = seg_decode(i_code);
        o_seg    = (SEG_ACT_LOW != 0) ? ~w_seg_hi : w_seg_hi;
    end

endmodule

// File: rtl/led7seg_scan_driver.sv
// Four-digit common-anode 7-segment scan driver: frame-coherent input snapshot,
// per-slot anti-ghost blanking and registered anode/segment drive.
module led7seg_scan_driver
    import led7seg_pkg::*;
#(
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK_CYCLES = 16,
    parameter int AN_ACT_LOW   = 1,
    parameter int SEG_ACT_LOW  = 1
) (
    input  logic       I_CLK,
    input  logic       I_RESET,
    input  logic [3:0] I_LED7SEG3,
    input  logic [3:0] I_LED7SEG2,
    input  logic [3:0] I_LED7SEG1,
    input  logic [3:0] I_LED7SEG0,
    input  logic [3:0] I_LEDDRVEN,
    input  logic [3:0] I_LEDDOTS,
    output logic [3:0] O_AN,
    output logic [6:0] O_SEG,
    output logic       O_DP,
    output logic       O_FRAME_STB
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0]      BLANK_END = DIV_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = (AN_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [6:0]            SEG_OFF   = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF    = (SEG_ACT_LOW != 0) ? 1'b1 : 1'b0;

    logic [DIV_W-1:0]           r_div;
    logic [IDX_W-1:0]           r_idx;
    logic                       r_first;

    logic [NUM_DIGITS-1:0][3:0] r_snap_dig;
    logic [NUM_DIGITS-1:0]      r_snap_drven;
    logic [NUM_DIGITS-1:0]      r_snap_dots;

    logic                       w_div_wrap;
    logic                       w_snap;
    logic                       w_blank;
    logic                       w_active;
    logic [3:0]                 w_code;
    logic [6:0]                 w_seg_dec;
    logic [NUM_DIGITS-1:0]      w_an_onehot;
    logic [NUM_DIGITS-1:0]      w_an_next;
    logic [6:0]                 w_seg_next;
    logic                       w_dp_next;

    logic [NUM_DIGITS-1:0]      r_an_p1;
    logic [6:0]                 r_seg_p1;
    logic                       r_dp_p1;
    logic                       r_stb_p1;

    // Snapshot only at the very end of a frame (or right after reset) so a
    // frame never mixes old and new digit data.
    assign w_div_wrap = (r_div == DIV_LAST);
    assign w_snap     = r_first || (w_div_wrap && (r_idx == IDX_LAST));

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_div    <= '0;
            r_idx    <= '0;
            r_first  <= 1'b1;
            r_stb_p1 <= 1'b0;
        end else begin
            r_first  <= 1'b0;
            r_stb_p1 <= w_snap;
            if (w_div_wrap) begin
                r_div <= '0;
                r_idx <= r_idx + IDX_W'(1);
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_snap_dig   <= '0;
            r_snap_drven <= '0;
            r_snap_dots  <= '0;
        end else if (w_snap) begin
            r_snap_dig   <= {I_LED7SEG3, I_LED7SEG2, I_LED7SEG1, I_LED7SEG0};
            r_snap_drven <= I_LEDDRVEN;
            r_snap_dots  <= I_LEDDOTS;
        end
    end

    // Stage p0: slot decode from the current (r_idx, r_div) and snapshot
    assign w_code      = r_snap_dig[r_idx];
    assign w_blank     = (r_div < BLANK_END);
    assign w_active    = !w_blank && r_snap_drven[r_idx];
    assign w_an_onehot = NUM_DIGITS'(1) << r_idx;

    led7seg_hex_decode #(
        .SEG_ACT_LOW(SEG_ACT_LOW)
    ) u_hex_decode (
        .i_code(w_code),
        .o_seg (w_seg_dec)
    );

    always_comb begin
        w_an_next  = AN_OFF;
        w_seg_next = SEG_OFF;
        w_dp_next  = DP_OFF;
        if (w_active) begin
            w_an_next  = (AN_ACT_LOW != 0) ? ~w_an_onehot : w_an_onehot;
            w_seg_next = w_seg_dec;
            w_dp_next  = r_snap_dots[r_idx] ? ~DP_OFF : DP_OFF;
        end
    end

    // Stage p1: registered pin drive
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_an_p1  <= AN_OFF;
            r_seg_p1 <= SEG_OFF;
            r_dp_p1  <= DP_OFF;
        end else begin
            r_an_p1  <= w_an_next;
            r_seg_p1 <= w_seg_next;
            r_dp_p1  <= w_dp_next;
        end
    end

    assign O_AN        = r_an_p1;
    assign O_SEG       = r_seg_p1;
    assign O_DP        = r_dp_p1;
    assign O_FRAME_STB = r_stb_p1;

endmodule

// File: tb/tb_led7seg_scan_driver.sv
// Directed bench for led7seg_scan_driver (SCAN_DIV=8, BLANK_CYCLES=2, active-low pins).
module tb_led7seg_scan_driver;

    logic       clk;
    logic       rst;
    logic [3:0] dig3, dig2, dig1, dig0;
    logic [3:0] drven, dots;
    logic [3:0] an, an_nb;
    logic [6:0] seg, seg_nb;
    logic       dp, dp_nb;
    logic       stb, stb_nb;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Hand-inverted segment patterns for hex 0..F (active-low cathodes)
    logic [6:0] inv_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    led7seg_scan_driver #(
        .SCAN_DIV(8), .BLANK_CYCLES(2), .AN_ACT_LOW(1), .SEG_ACT_LOW(1)
    ) u_dut (
        .I_CLK(clk), .I_RESET(rst),
        .I_LED7SEG3(dig3), .I_LED7SEG2(dig2), .I_LED7SEG1(dig1), .I_LED7SEG0(dig0),
        .I_LEDDRVEN(drven), .I_LEDDOTS(dots),
        .O_AN(an), .O_SEG(seg), .O_DP(dp), .O_FRAME_STB(stb)
    );

    led7seg_scan_driver #(
        .SCAN_DIV(8), .BLANK_CYCLES(0), .AN_ACT_LOW(1), .SEG_ACT_LOW(1)
    ) u_dut_nb (
        .I_CLK(clk), .I_RESET(rst),
        .I_LED7SEG3(dig3), .I_LED7SEG2(dig2), .I_LED7SEG1(dig1), .I_LED7SEG0(dig0),
        .I_LEDDRVEN(drven), .I_LEDDOTS(dots),
        .O_AN(an_nb), .O_SEG(seg_nb), .O_DP(dp_nb), .O_FRAME_STB(stb_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // After tick() the outputs reflect scan state number cyc (cyc=0: first post-reset state)
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [3:0] an_on(input int s);
        logic [3:0] oh;
        oh = 4'b0001 << s;
        return ~oh;
    endfunction

    always @(negedge clk) begin
        n_total++;
        if ($countones(~an) > 1 || $countones(~an_nb) > 1)
            $display("FAIL onehot_an t=%0t an=%h an_nb=%h required at most one low bit", $time, an, an_nb);
        else
            n_pass++;
    end

    task automatic test_reset();
        rst = 1'b1;
        dig3 = 4'd1; dig2 = 4'd2; dig1 = 4'd3; dig0 = 4'd4;
        drven = 4'hF; dots = 4'h0;
        repeat (3) begin
            tick();
            n_total++; if (an !== 4'hF) $display("FAIL rst_an got=%h exp=F", an); else n_pass++;
            n_total++; if (seg !== 7'h7F) $display("FAIL rst_seg got=%h exp=7F", seg); else n_pass++;
            n_total++; if (dp !== 1'b1) $display("FAIL rst_dp got=%b exp=1", dp); else n_pass++;
            n_total++; if (stb !== 1'b0) $display("FAIL rst_stb got=%b exp=0", stb); else n_pass++;
        end
        rst = 1'b0;
        cyc = -1;
        tick();
        n_total++; if (stb !== 1'b1) $display("FAIL first_snap_stb got=%b exp=1", stb); else n_pass++;
        n_total++; if (an !== 4'hF) $display("FAIL first_an got=%h exp=F", an); else n_pass++;
        tick();
        n_total++; if (stb !== 1'b0) $display("FAIL stb_single got=%b exp=0", stb); else n_pass++;
    endtask

    task automatic test_scan();
        int dig [4];
        int s, d;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        dig[0] = 4; dig[1] = 3; dig[2] = 2; dig[3] = 1;
        while (cyc < 63) begin
            tick();
            s = (cyc / 8) % 4;
            d = cyc % 8;
            e_an  = (d < 2) ? 4'hF : an_on(s);
            e_seg = (d < 2) ? 7'h7F : inv_tab[dig[s]];
            n_total++; if (an !== e_an) $display("FAIL scan_an cyc=%0d got=%h exp=%h", cyc, an, e_an); else n_pass++;
            n_total++; if (seg !== e_seg) $display("FAIL scan_seg cyc=%0d got=%h exp=%h", cyc, seg, e_seg); else n_pass++;
            n_total++; if (dp !== 1'b1) $display("FAIL scan_dp cyc=%0d got=%b exp=1", cyc, dp); else n_pass++;
            n_total++; if (stb !== (cyc % 32 == 31)) $display("FAIL scan_stb cyc=%0d got=%b", cyc, stb); else n_pass++;
            n_total++; if (an_nb !== an_on(s)) $display("FAIL noblank_an cyc=%0d got=%h exp=%h", cyc, an_nb, an_on(s)); else n_pass++;
            n_total++; if (seg_nb !== inv_tab[dig[s]]) $display("FAIL noblank_seg cyc=%0d got=%h exp=%h", cyc, seg_nb, inv_tab[dig[s]]); else n_pass++;
            n_total++; if (dp_nb !== 1'b1 || stb_nb !== stb) $display("FAIL noblank_dp_stb cyc=%0d dp=%b stb=%b", cyc, dp_nb, stb_nb); else n_pass++;
        end
    endtask

    task automatic test_midframe_change();
        int dig [4];
        int s, d, n_stb;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        dig[1] = 3; dig[2] = 2; dig[3] = 1;
        n_stb = 0;
        while (cyc < 127) begin
            tick();
            if (cyc == 75) dig0 = 4'hF;
            dig[0] = (cyc >= 96) ? 15 : 4;
            s = (cyc / 8) % 4;
            d = cyc % 8;
            e_an  = (d < 2) ? 4'hF : an_on(s);
            e_seg = (d < 2) ? 7'h7F : inv_tab[dig[s]];
            if (stb === 1'b1) n_stb++;
            n_total++; if (an !== e_an) $display("FAIL mid_an cyc=%0d got=%h exp=%h", cyc, an, e_an); else n_pass++;
            n_total++; if (seg !== e_seg) $display("FAIL mid_seg cyc=%0d got=%h exp=%h", cyc, seg, e_seg); else n_pass++;
        end
        n_total++; if (n_stb != 2) $display("FAIL mid_stb_count got=%0d exp=2", n_stb); else n_pass++;
    endtask

    task automatic test_drven_dots();
        int dig [4];
        int s, d;
        logic [3:0] cfg_en, cfg_dp, e_an;
        logic [6:0] e_seg;
        logic       act, e_dp;
        dig[0] = 15; dig[1] = 3; dig[2] = 2; dig[3] = 1;
        drven = 4'b0101;
        dots  = 4'b0001;
        while (cyc < 191) begin
            tick();
            cfg_en = (cyc >= 160) ? 4'b0101 : 4'b1111;
            cfg_dp = (cyc >= 160) ? 4'b0001 : 4'b0000;
            s = (cyc / 8) % 4;
            d = cyc % 8;
            act   = (d >= 2) && cfg_en[s];
            e_an  = act ? an_on(s) : 4'hF;
            e_seg = act ? inv_tab[dig[s]] : 7'h7F;
            e_dp  = (act && cfg_dp[s]) ? 1'b0 : 1'b1;
            n_total++; if (an !== e_an) $display("FAIL en_an cyc=%0d got=%h exp=%h", cyc, an, e_an); else n_pass++;
            n_total++; if (seg !== e_seg) $display("FAIL en_seg cyc=%0d got=%h exp=%h", cyc, seg, e_seg); else n_pass++;
            n_total++; if (dp !== e_dp) $display("FAIL en_dp cyc=%0d got=%b exp=%b", cyc, dp, e_dp); else n_pass++;
        end
    endtask

    task automatic test_reset_midslot();
        int dig [4];
        int s, d;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        while (cyc < 212) tick();
        // current state is slot 2, div 5
        rst   = 1'b1;
        dig2  = 4'h7;
        drven = 4'hF;
        tick();
        n_total++; if (an !== 4'hF) $display("FAIL mid_rst_an got=%h exp=F", an); else n_pass++;
        n_total++; if (seg !== 7'h7F) $display("FAIL mid_rst_seg got=%h exp=7F", seg); else n_pass++;
        n_total++; if (dp !== 1'b1) $display("FAIL mid_rst_dp got=%b exp=1", dp); else n_pass++;
        n_total++; if (stb !== 1'b0) $display("FAIL mid_rst_stb got=%b exp=0", stb); else n_pass++;
        rst = 1'b0;
        cyc = -1;
        tick();
        n_total++; if (stb !== 1'b1) $display("FAIL resnap_stb got=%b exp=1", stb); else n_pass++;
        dig[0] = 15; dig[1] = 3; dig[2] = 7; dig[3] = 1;
        while (cyc < 31) begin
            tick();
            s = (cyc / 8) % 4;
            d = cyc % 8;
            e_an  = (d < 2) ? 4'hF : an_on(s);
            e_seg = (d < 2) ? 7'h7F : inv_tab[dig[s]];
            e_dp  = (d >= 2 && s == 0) ? 1'b0 : 1'b1;
            n_total++; if (an !== e_an) $display("FAIL restart_an cyc=%0d got=%h exp=%h", cyc, an, e_an); else n_pass++;
            n_total++; if (seg !== e_seg) $display("FAIL restart_seg cyc=%0d got=%h exp=%h", cyc, seg, e_seg); else n_pass++;
            n_total++; if (dp !== e_dp) $display("FAIL restart_dp cyc=%0d got=%b exp=%b", cyc, dp, e_dp); else n_pass++;
        end
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 16; v++) begin
            dig0 = 4'(v);
            do tick(); while (cyc % 32 != 31);
            repeat (4) tick();
            n_total++; if (seg !== inv_tab[v]) $display("FAIL sweep_seg v=%0d got=%h exp=%h", v, seg, inv_tab[v]); else n_pass++;
            n_total++; if (an !== 4'hE) $display("FAIL sweep_an v=%0d got=%h exp=E", v, an); else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        dig3 = '0; dig2 = '0; dig1 = '0; dig0 = '0;
        drven = '0; dots = '0;
        test_reset();
        test_scan();
        test_midframe_change();
        test_drven_dots();
        test_reset_midslot();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
